store_align_unit: RTL and testbench

Parametrised store-path aligner placed between the LSU address/data stage and the data-memory write port. It places sb/sh/sw/sd data into little-endian byte lanes of a BUS_W-wide bus and generates per-byte write strobes. It registers each request behind a valid/ready handshake. Stores that cross a bus-word boundary are split into two sequential bus beats.

---
 rtl/store_align_unit.sv | 158 +++++++++++++++
 tb/tb_store_align_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/store_align_unit.sv
// Store-path aligner: lane-aligns sb/sh/sw/sd data and strobes onto a BUS_W bus.
// Optional macro STORE_MISALIGN_SPLIT_EN splits bus-word-crossing stores into two beats.
module store_align_unit #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned BUS_W  = 32,
  parameter int unsigned XLEN   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_func3,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [XLEN-1:0]       req_wdata,
  output logic                  bus_valid,
  input  logic                  bus_ready,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [BUS_W-1:0]      bus_wdata,
  output logic [BUS_W/8-1:0]    bus_wstrb,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned NB = BUS_W / 8;
  localparam int unsigned OW = $clog2(NB);
  localparam int unsigned XB = XLEN / 8;

`ifdef STORE_MISALIGN_SPLIT_EN
  localparam int unsigned LANES = 2 * NB;
  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, ERR} state_e;
`else
  localparam int unsigned LANES = NB;
  typedef enum logic [1:0] {IDLE, BEAT0, ERR} state_e;
`endif

  state_e                state_q;
  logic                  bus_valid_q;
  logic [ADDR_W-1:0]     bus_addr_q;
  logic [BUS_W-1:0]      bus_wdata_q;
  logic [NB-1:0]         bus_wstrb_q;
  logic                  done_q;
  logic                  err_q;
`ifdef STORE_MISALIGN_SPLIT_EN
  logic                  split_q;
  logic [BUS_W-1:0]      hi_wdata_q;
  logic [NB-1:0]         hi_wstrb_q;
`endif

  int unsigned           size_b;
  int unsigned           off;
  logic [ADDR_W-1:0]     base;
  logic                  split;
  logic                  legal;
  logic [8*LANES-1:0]    data_wide;
  logic [LANES-1:0]      strb_wide;

  // Lanes NB..2*NB-1 of the wide image form the second beat of a split store.
  always_comb begin
    size_b    = 32'd1 << req_func3[1:0];
    off       = 32'(req_addr[OW-1:0]);
    base      = {req_addr[ADDR_W-1:OW], {OW{1'b0}}};
    split     = (off + size_b) > NB;
`ifdef STORE_MISALIGN_SPLIT_EN
    legal     = !req_func3[2] && (size_b <= NB);
`else
    legal     = !req_func3[2] && (size_b <= NB) && !split;
`endif
    data_wide = '0;
    strb_wide = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      if (i < size_b && (i + off) < LANES) begin
        strb_wide[i + off] = 1'b1;
        if (i < XB) data_wide[8*(i + off) +: 8] = req_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bus_valid_q <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_wstrb_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef STORE_MISALIGN_SPLIT_EN
      split_q     <= 1'b0;
      hi_wdata_q  <= '0;
      hi_wstrb_q  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            if (legal) begin
              state_q     <= BEAT0;
              bus_valid_q <= 1'b1;
              bus_addr_q  <= base;
              bus_wdata_q <= data_wide[BUS_W-1:0];
              bus_wstrb_q <= strb_wide[NB-1:0];
`ifdef STORE_MISALIGN_SPLIT_EN
              split_q     <= split;
              hi_wdata_q  <= data_wide[8*LANES-1 -: BUS_W];
              hi_wstrb_q  <= strb_wide[LANES-1 -: NB];
`endif
            end else begin
              state_q <= ERR;
              err_q   <= 1'b1;
            end
          end
        end
        BEAT0: begin
          if (bus_ready) begin
`ifdef STORE_MISALIGN_SPLIT_EN
            if (split_q) begin
              state_q     <= BEAT1;
              bus_addr_q  <= bus_addr_q + ADDR_W'(NB);
              bus_wdata_q <= hi_wdata_q;
              bus_wstrb_q <= hi_wstrb_q;
            end else begin
              state_q     <= IDLE;
              bus_valid_q <= 1'b0;
              done_q      <= 1'b1;
            end
`else
            state_q     <= IDLE;
            bus_valid_q <= 1'b0;
            done_q      <= 1'b1;
`endif
          end
        end
`ifdef STORE_MISALIGN_SPLIT_EN
        BEAT1: begin
          if (bus_ready) begin
            state_q     <= IDLE;
            bus_valid_q <= 1'b0;
            done_q      <= 1'b1;
          end
        end
`endif
        ERR:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == IDLE);
  assign bus_valid = bus_valid_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_wstrb = bus_wstrb_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_store_align_unit.sv
// Self-checking bench: directed and random stores on a 32-bit and a 64-bit bus instance,
// checked against a byte-lane reference model.
module tb_store_align_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 32-bit bus instance
  logic        r0_valid = 1'b0;
  logic [2:0]  r0_f3 = '0;
  logic [31:0] r0_addr = '0;
  logic [31:0] r0_wdata = '0;
  logic        b0_ready = 1'b0;
  logic        o0_ready, b0_valid, d0_done, d0_err;
  logic [31:0] b0_addr, b0_wdata;
  logic [3:0]  b0_wstrb;

  // 64-bit bus instance
  logic        r1_valid = 1'b0;
  logic [2:0]  r1_f3 = '0;
  logic [31:0] r1_addr = '0;
  logic [63:0] r1_wdata = '0;
  logic        b1_ready = 1'b0;
  logic        o1_ready, b1_valid, d1_done, d1_err;
  logic [31:0] b1_addr;
  logic [63:0] b1_wdata;
  logic [7:0]  b1_wstrb;

  store_align_unit #(.ADDR_W(32), .BUS_W(32), .XLEN(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(r0_valid), .req_ready(o0_ready), .req_func3(r0_f3),
    .req_addr(r0_addr), .req_wdata(r0_wdata),
    .bus_valid(b0_valid), .bus_ready(b0_ready), .bus_addr(b0_addr),
    .bus_wdata(b0_wdata), .bus_wstrb(b0_wstrb), .done(d0_done), .err(d0_err)
  );

  store_align_unit #(.ADDR_W(32), .BUS_W(64), .XLEN(64)) u_dut64 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(r1_valid), .req_ready(o1_ready), .req_func3(r1_f3),
    .req_addr(r1_addr), .req_wdata(r1_wdata),
    .bus_valid(b1_valid), .bus_ready(b1_ready), .bus_addr(b1_addr),
    .bus_wdata(b1_wdata), .bus_wstrb(b1_wstrb), .done(d1_done), .err(d1_err)
  );

`ifdef STORE_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: place data byte k at absolute lane o+k; lanes >= nb belong to the next bus word.
  task automatic model(input int unsigned nb, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [63:0] wd, output bit legal, output int nbeats,
                       output logic [31:0] a0, output logic [31:0] a1,
                       output logic [63:0] d0, output logic [63:0] d1,
                       output logic [7:0] s0, output logic [7:0] s1);
    int unsigned sz, o, lane;
    logic [63:0] byt;
    sz = 1 << f3[1:0];
    o  = addr % nb;
    legal  = (f3[2] == 1'b0) && (sz <= nb) && (SPLIT_EN || (o + sz <= nb));
    nbeats = (o + sz > nb) ? 2 : 1;
    a0 = addr - o;
    a1 = a0 + nb;
    d0 = '0; d1 = '0; s0 = '0; s1 = '0;
    for (int unsigned k = 0; k < sz; k++) begin
      lane = o + k;
      byt  = (wd >> (8 * k)) & 64'hFF;
      if (lane < nb) begin
        d0 = d0 | (byt << (8 * lane));
        s0[lane] = 1'b1;
      end else begin
        d1 = d1 | (byt << (8 * (lane - nb)));
        s1[lane - nb] = 1'b1;
      end
    end
  endtask

  task automatic sample(input int u, output logic rdy, output logic bv, output logic [31:0] ba,
                        output logic [63:0] bd, output logic [7:0] bs,
                        output logic dn, output logic er);
    if (u == 0) begin
      rdy = o0_ready; bv = b0_valid; ba = b0_addr; bd = {32'b0, b0_wdata};
      bs = {4'b0, b0_wstrb}; dn = d0_done; er = d0_err;
    end else begin
      rdy = o1_ready; bv = b1_valid; ba = b1_addr; bd = b1_wdata;
      bs = b1_wstrb; dn = d1_done; er = d1_err;
    end
  endtask

  task automatic drive_req(input int u, input logic v, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [63:0] wd);
    if (u == 0) begin
      r0_valid = v; r0_f3 = f3; r0_addr = addr; r0_wdata = wd[31:0];
    end else begin
      r1_valid = v; r1_f3 = f3; r1_addr = addr; r1_wdata = wd;
    end
  endtask

  task automatic set_bus_ready(input int u, input logic r);
    if (u == 0) b0_ready = r;
    else        b1_ready = r;
  endtask

  task automatic check_reset_outputs(input int u);
    logic rdy, bv, dn, er;
    logic [31:0] ba;
    logic [63:0] bd;
    logic [7:0] bs;
    sample(u, rdy, bv, ba, bd, bs, dn, er);
    chk("rst_req_ready", 64'(rdy), 64'd1);
    chk("rst_bus_valid", 64'(bv), 64'd0);
    chk("rst_bus_addr", 64'(ba), 64'd0);
    chk("rst_bus_wdata", bd, 64'd0);
    chk("rst_bus_wstrb", 64'(bs), 64'd0);
    chk("rst_done", 64'(dn), 64'd0);
    chk("rst_err", 64'(er), 64'd0);
  endtask

  task automatic do_store(input int u, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [63:0] wd, input int stall);
    bit legal;
    int nbeats;
    logic [31:0] ea[2];
    logic [63:0] ed[2];
    logic [7:0]  es[2];
    logic rdy, bv, dn, er;
    logic [31:0] ba;
    logic [63:0] bd;
    logic [7:0] bs;
    int unsigned nb;
    nb = (u == 0) ? 4 : 8;
    model(nb, f3, addr, wd, legal, nbeats, ea[0], ea[1], ed[0], ed[1], es[0], es[1]);

    @(negedge clk);
    sample(u, rdy, bv, ba, bd, bs, dn, er);
    chk("req_ready_idle", 64'(rdy), 64'd1);
    drive_req(u, 1'b1, f3, addr, wd);
    @(negedge clk);
    drive_req(u, 1'b0, 3'($urandom_range(0, 7)), $urandom, {$urandom, $urandom});

    if (!legal) begin
      sample(u, rdy, bv, ba, bd, bs, dn, er);
      chk("err_pulse", 64'(er), 64'd1);
      chk("err_no_beat", 64'(bv), 64'd0);
      chk("err_no_done", 64'(dn), 64'd0);
      @(negedge clk);
      sample(u, rdy, bv, ba, bd, bs, dn, er);
      chk("err_cleared", 64'(er), 64'd0);
      chk("err_no_beat_after", 64'(bv), 64'd0);
      chk("err_ready_back", 64'(rdy), 64'd1);
      return;
    end

    for (int b = 0; b < nbeats; b++) begin
      for (int c = 0; c <= stall; c++) begin
        set_bus_ready(u, (c == stall) ? 1'b1 : 1'b0);
        sample(u, rdy, bv, ba, bd, bs, dn, er);
        chk("beat_valid", 64'(bv), 64'd1);
        chk("beat_addr", 64'(ba), 64'(ea[b]));
        chk("beat_wdata", bd, ed[b]);
        chk("beat_wstrb", 64'(bs), 64'(es[b]));
        chk("beat_req_ready", 64'(rdy), 64'd0);
        chk("beat_no_done", 64'(dn), 64'd0);
        chk("beat_no_err", 64'(er), 64'd0);
        @(negedge clk);
      end
    end
    set_bus_ready(u, 1'b0);
    sample(u, rdy, bv, ba, bd, bs, dn, er);
    chk("done_pulse", 64'(dn), 64'd1);
    chk("done_bus_idle", 64'(bv), 64'd0);
    chk("done_ready", 64'(rdy), 64'd1);
    chk("done_no_err", 64'(er), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] f3;
    logic rdy, bv, dn, er;
    logic [31:0] ba;
    logic [63:0] bd;
    logic [7:0] bs;

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs(0);
    check_reset_outputs(1);
    rst_n = 1'b1;

    // 32-bit directed cases
    do_store(0, 3'b010, 32'h0000_0100, 64'hDEAD_BEEF, 0);
    do_store(0, 3'b000, 32'h0000_0103, 64'h0000_00AB, 0);
    do_store(0, 3'b001, 32'h0000_0102, 64'h0000_1234, 0);
    do_store(0, 3'b001, 32'h0000_0103, 64'h0000_1234, 0);
    do_store(0, 3'b010, 32'h0000_0100, 64'hCAFE_F00D, 3);
    do_store(0, 3'b011, 32'h0000_0100, 64'h1122_3344, 0);
    do_store(0, 3'b100, 32'h0000_0100, 64'h1122_3344, 0);
    do_store(0, 3'b001, 32'hFFFF_FFFF, 64'h0000_5A6B, 1);
    do_store(0, 3'b010, 32'h0000_0101, 64'h0102_0304, 2);

    // 64-bit directed cases
    do_store(1, 3'b011, 32'h0000_0208, 64'h0123_4567_89AB_CDEF, 0);
    do_store(1, 3'b010, 32'h0000_020C, 64'h8765_4321, 0);
    do_store(1, 3'b011, 32'h0000_020C, 64'hFEDC_BA98_7654_3210, 1);
    do_store(1, 3'b111, 32'h0000_0200, 64'h1, 0);

    // Reset while a store is in flight (second beat when splitting is enabled)
    @(negedge clk);
    if (SPLIT_EN) drive_req(0, 1'b1, 3'b001, 32'h0000_0103, 64'h1234);
    else          drive_req(0, 1'b1, 3'b010, 32'h0000_0100, 64'hA5A5_A5A5);
    @(negedge clk);
    drive_req(0, 1'b0, 3'b000, 32'h0, 64'h0);
    b0_ready = SPLIT_EN;
    @(negedge clk);
    b0_ready = 1'b0;
    sample(0, rdy, bv, ba, bd, bs, dn, er);
    chk("inflight_valid", 64'(bv), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs(0);
    rst_n = 1'b1;
    do_store(0, 3'b010, 32'h0000_0300, 64'h0BAD_F00D, 0);

    // Random stores on both instances
    for (int n = 0; n < 300; n++) begin
      f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      do_store(n % 2, f3, ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF8 | 32'($urandom_range(0, 7))) : $urandom,
               {$urandom, $urandom}, $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
